// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer: RMII TX framer - preamble, SFD, payload, optional pad, CRC-32 FCS, IFG.
// Build option: define RMII_TX_PAD_EN to zero-pad short payloads up to MIN_PAYLOAD bytes.
module rmii_tx_framer #(
   parameter int PREAMBLE_BYTES = 7,
`ifdef RMII_TX_PAD_EN
   parameter int MIN_PAYLOAD    = 60,
`endif
   parameter int IFG_BYTES      = 12
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   input  logic       i_last,
   output logic       o_ready,
   output logic [1:0] o_txd,
   output logic       o_txen,
   output logic       o_busy,
   output logic       o_underrun
);
   typedef enum logic [2:0] {
      IDLE, PRE, SFD, DATA, FCS, IFG
`ifdef RMII_TX_PAD_EN
      , PAD
`endif
   } state_t;
   state_t      state_q, state_d;
   logic [1:0]  dib_q, dib_d, txd_q, txd_d;
   logic [10:0] cnt_q, cnt_d, cnt_inc;
   logic [7:0]  sh_q, sh_d;
   logic [31:0] crc_q, crc_d, crc_upd, fcs;
   logic        last_q, last_d, txen_q, txen_d, und_q, und_d, byte_end;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
      return r;
   endfunction

   assign byte_end   = dib_q == 2'd3;
   assign cnt_inc    = &cnt_q ? cnt_q : cnt_q + 11'd1;
   assign crc_upd    = crc_byte(crc_q, sh_q);
   assign fcs        = ~crc_d;
   assign o_ready    = byte_end && (state_q == SFD || (state_q == DATA && !last_q));
   assign o_txd      = txd_q;
   assign o_txen     = txen_q;
   assign o_busy     = state_q != IDLE;
   assign o_underrun = und_q;

   // State and counters describe the dibit that will be on the wire next cycle.
   always_comb begin
      state_d = state_q;
      dib_d   = dib_q + 2'd1;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      last_d  = last_q;
      crc_d   = crc_q;
      und_d   = 1'b0;
      case (state_q)
         IDLE: begin
            dib_d   = 2'd0;
            cnt_d   = '0;
            crc_d   = '1;
            last_d  = 1'b0;
            state_d = i_valid ? PRE : IDLE;
         end
         PRE: if (byte_end) begin
            state_d = cnt_q == 11'(PREAMBLE_BYTES - 1) ? SFD : PRE;
            cnt_d   = cnt_q == 11'(PREAMBLE_BYTES - 1) ? '0 : cnt_q + 11'd1;
         end
         SFD, DATA: if (byte_end) begin
            crc_d = state_q == DATA ? crc_upd : crc_q;
            if (o_ready && !i_valid) begin
               state_d = IFG;
               cnt_d   = '0;
               und_d   = 1'b1;
            end else if (o_ready) begin
               state_d = DATA;
               sh_d    = i_data;
               last_d  = i_last;
               cnt_d   = state_q == SFD ? 11'd1 : cnt_inc;
            end else begin
`ifdef RMII_TX_PAD_EN
               state_d = cnt_q < 11'(MIN_PAYLOAD) ? PAD : FCS;
               cnt_d   = cnt_q < 11'(MIN_PAYLOAD) ? cnt_q : '0;
               sh_d    = '0;
`else
               state_d = FCS;
               cnt_d   = '0;
`endif
            end
         end
`ifdef RMII_TX_PAD_EN
         PAD: if (byte_end) begin
            crc_d   = crc_upd;
            state_d = cnt_inc == 11'(MIN_PAYLOAD) ? FCS : PAD;
            cnt_d   = cnt_inc == 11'(MIN_PAYLOAD) ? '0 : cnt_inc;
         end
`endif
         FCS: if (byte_end) begin
            state_d = cnt_q == 11'd3 ? IFG : FCS;
            cnt_d   = cnt_q == 11'd3 ? '0 : cnt_q + 11'd1;
            dib_d   = cnt_q == 11'd3 ? 2'd1 : 2'd0;
         end
         IFG: if (byte_end) begin
            state_d = cnt_q == 11'(IFG_BYTES - 1) ? IDLE : IFG;
            cnt_d   = cnt_q + 11'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // After a normal FCS the IFG counter starts one clock in: the IDLE sampling
   // cycle completes the quiet gap, so back-to-back frames see exactly IFG_BYTES*4.
   always_comb begin
      txen_d = state_d != IDLE && state_d != IFG;
      txd_d  = state_d == PRE ? 2'b01
             : state_d == SFD ? {dib_d == 2'd3, 1'b1}
             : state_d == FCS ? fcs[{cnt_d[1:0], dib_d, 1'b0} +: 2]
             : txen_d ? sh_d[{dib_d, 1'b0} +: 2] : 2'b00;
   end

   // State, counters, CRC and registered RMII outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         dib_q   <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         last_q  <= 1'b0;
         crc_q   <= '1;
         txd_q   <= '0;
         txen_q  <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dib_q   <= dib_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         last_q  <= last_d;
         crc_q   <= crc_d;
         txd_q   <= txd_d;
         txen_q  <= txen_d;
         und_q   <= und_d;
      end
   end
endmodule
